// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: owns the fetch PC, buffers redirects that arrive while stalled,
// and tags each fetch with address-error and branch-delay-slot information for CP0.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        f_is_branch,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        f_valid,
    output logic        f_bd,
    output logic        f_exc,
    output logic [4:0]  f_exc_code
);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e      state;
    logic [31:0] pend_target;
    logic        pend_valid;
    logic        addr_err;

    // A buffered redirect exists exactly while the FSM sits in HOLD.
    assign pend_valid = (state == StHold);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= StRun;
            pend_target <= '0;
            f_bd        <= 1'b0;
            f_valid     <= 1'b0;
        end else if (exc_req) begin
            pc          <= HANDLER_PC;
            state       <= StRun;
            pend_target <= '0;
            f_bd        <= 1'b0;
            f_valid     <= 1'b1;
        end else if (eret_req) begin
            pc          <= epc;
            state       <= StRun;
            pend_target <= '0;
            f_bd        <= 1'b0;
            f_valid     <= 1'b1;
        end else if (stall) begin
            // pc, f_bd and f_valid hold; a newer redirect replaces any older buffered one.
            if (redirect) begin
                pend_target <= redirect_target;
                state       <= StHold;
            end
        end else begin
            f_bd    <= f_is_branch;
            f_valid <= 1'b1;
            state   <= StRun;
            if (redirect) begin
                pc <= redirect_target;
            end else if (pend_valid) begin
                pc <= pend_target;
            end else begin
                pc <= pc + 32'd4;
            end
        end
    end

    // Out-of-range or misaligned PCs are fetched anyway and flagged; CP0 handles the trap.
    assign addr_err   = (pc < TEXT_LO) || (pc > TEXT_HI) || (pc[1:0] != 2'b00);
    assign f_exc      = f_valid && addr_err;
    assign f_exc_code = f_exc ? EXC_ADEL : 5'd0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random traffic, all checked against
// a behavioural fetch-PC model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, f_is_branch, exc_req, eret_req;
    logic [31:0] redirect_target, epc;
    logic [31:0] pc;
    logic        f_valid, f_bd, f_exc;
    logic [4:0]  f_exc_code;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid, m_bd, m_pend;
    logic [31:0] m_pend_t;

    pc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .f_is_branch    (f_is_branch),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .pc             (pc),
        .f_valid        (f_valid),
        .f_bd           (f_bd),
        .f_exc          (f_exc),
        .f_exc_code     (f_exc_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and compare after the edge.
    task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rt,
                         input logic br, input logic ex, input logic er,
                         input logic [31:0] ep);
        logic        bad;
        logic [4:0]  code;
        reset = r; stall = s; redirect = rd; redirect_target = rt;
        f_is_branch = br; exc_req = ex; eret_req = er; epc = ep;
        if (r) begin
            m_pc = 32'h3000; m_pend = 0; m_bd = 0; m_valid = 0;
        end else if (ex) begin
            m_pc = 32'h4180; m_pend = 0; m_bd = 0; m_valid = 1;
        end else if (er) begin
            m_pc = ep; m_pend = 0; m_bd = 0; m_valid = 1;
        end else if (s) begin
            if (rd) begin
                m_pend = 1; m_pend_t = rt;
            end
        end else begin
            if (rd) m_pc = rt;
            else if (m_pend) m_pc = m_pend_t;
            else m_pc = m_pc + 32'd4;
            m_pend = 0; m_bd = br; m_valid = 1;
        end
        @(posedge clk);
        #1;
        bad  = m_valid && (m_pc < 32'h3000 || m_pc > 32'h6ffc || (m_pc % 4) != 0);
        code = bad ? 5'd4 : 5'd0;
        check("pc", pc, m_pc);
        check("f_valid", {31'd0, f_valid}, {31'd0, m_valid});
        check("f_bd", {31'd0, f_bd}, {31'd0, m_bd});
        check("f_exc", {31'd0, f_exc}, {31'd0, bad});
        check("f_exc_code", {27'd0, f_exc_code}, {27'd0, code});
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        m_pc = 0; m_valid = 0; m_bd = 0; m_pend = 0; m_pend_t = 0;
        reset = 1; stall = 0; redirect = 0; redirect_target = 0;
        f_is_branch = 0; exc_req = 0; eret_req = 0; epc = 0;
        #2;

        // Reset, then free run 0x3000..0x3010
        cycle(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        check("reset_pc", pc, 32'h3000);
        free_run(4);
        check("free_run_pc", pc, 32'h3010);

        // Branch at 0x3008 then redirect: delay slot 0x300c gets f_bd=1
        cycle(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        free_run(2);
        cycle(0, 0, 0, 32'h0, 1, 0, 0, 32'h0);
        check("delay_slot_bd", {31'd0, f_bd}, 32'd1);
        cycle(0, 0, 1, 32'h3100, 0, 0, 0, 32'h0);
        check("redirect_pc", pc, 32'h3100);

        // Redirect buffered during a 3-cycle stall, taken on release
        cycle(0, 1, 1, 32'h3200, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
        check("stall_hold_pc", pc, 32'h3100);
        free_run(1);
        check("stall_release_pc", pc, 32'h3200);

        // Exception discards pending redirect; then ERET to misaligned epc
        cycle(0, 1, 1, 32'h3200, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 32'h0, 1, 1, 0, 32'h0);
        check("exc_pc", pc, 32'h4180);
        free_run(1);
        check("pend_discarded_pc", pc, 32'h4184);
        cycle(0, 0, 0, 32'h0, 0, 0, 1, 32'h3001);
        check("eret_exc_code", {27'd0, f_exc_code}, 32'd4);

        // Top of text segment and below it
        cycle(0, 0, 1, 32'h6ffc, 0, 0, 0, 32'h0);
        free_run(2);
        cycle(0, 0, 1, 32'h2ffc, 0, 0, 0, 32'h0);

        // exc beats eret; reset in HOLD clears the pending redirect
        cycle(0, 0, 0, 32'h0, 0, 1, 1, 32'h3400);
        check("exc_over_eret", pc, 32'h4180);
        cycle(0, 1, 1, 32'h3500, 0, 0, 0, 32'h0);
        cycle(1, 1, 0, 32'h0, 0, 0, 0, 32'h0);
        free_run(2);
        check("reset_clears_pend", pc, 32'h3008);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = 32'h2ff0 + ($urandom_range(0, 32'h4020) & 32'hffff_fffc);
            if ($urandom_range(0, 9) == 0) tgt = tgt | {30'd0, 2'($urandom_range(1, 3))};
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, tgt, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
                  32'h2ff8 + $urandom_range(0, 32'h4010));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
